// File: rtl/alu_wide_sequencer_if.sv
// alu_wide_sequencer bus definitions.
// alu_wide_sequencer_pkg : 8-bit ALU opcode encoding shared by the sequencer and its environment.
// alu_wide_sequencer_if  : control-unit request/response handshake plus the ALU operand/result wires.
//   slave  : the sequencer's view (serves requests, drives the ALU inputs).
//   master : the environment's view (control unit issuing requests, ALU returning results).
package alu_wide_sequencer_pkg;
  typedef enum logic [3:0] {
    kADD  = 4'd0,
    kXOR  = 4'd1,
    kAND  = 4'd2,
    kCOMP = 4'd3
  } alu_op_e;
endpackage

interface alu_wide_sequencer_if #(
  parameter int W_DATA = 16,
  parameter int W_ALU  = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [W_DATA-1:0] req_a;
  logic [W_DATA-1:0] req_b;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [W_DATA-1:0] rsp_result;
  logic              rsp_zero;
  logic              rsp_greater;
  logic              rsp_carry;
  logic              rsp_err;

  logic [W_ALU-1:0]  alu_a;
  logic [W_ALU-1:0]  alu_b;
  logic [3:0]        alu_op;
  logic              alu_sc_in;
  logic [W_ALU-1:0]  alu_out;
  logic              alu_zero;
  logic              alu_greater;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, alu_out, alu_zero, alu_greater,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_greater, rsp_carry, rsp_err,
           alu_a, alu_b, alu_op, alu_sc_in
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, alu_out, alu_zero, alu_greater,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_greater, rsp_carry, rsp_err,
           alu_a, alu_b, alu_op, alu_sc_in
  );
endinterface

// File: rtl/alu_wide_sequencer.sv
// alu_wide_sequencer: runs 16-bit ADD/XOR/AND/COMP (and optionally SUB) as two
// byte passes (low then high) over an external 8-bit combinational ALU, chaining
// the carry between the passes. One transaction in flight; no overlap.
// Optional feature macro: SEQ_SUB_EN -- REQ_OP=4 becomes SUB (A + ~B + 1);
// without it op 4 is reported as illegal and no operand inversion exists.
module alu_wide_sequencer #(
  parameter int W_DATA = 16          // must be twice the 8-bit ALU width
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_wide_sequencer_if.slave bus
);
  import alu_wide_sequencer_pkg::*;

  localparam int W_ALU = W_DATA / 2;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

  typedef struct packed {
    logic [2:0]        op;
    logic [W_DATA-1:0] a;
    logic [W_DATA-1:0] b;   // already inverted for SUB
  } req_t;

  state_e            state;
  req_t              req;
  logic [W_ALU-1:0]  res_lo;
  logic              z_lo, g_lo;

  // registered outputs
  logic              req_ready_q;
  logic              rsp_valid_q, rsp_zero_q, rsp_greater_q, rsp_carry_q, rsp_err_q;
  logic [W_DATA-1:0] rsp_result_q;
  logic [W_ALU-1:0]  alu_a_q, alu_b_q;
  logic [3:0]        alu_op_q;
  logic              alu_sc_in_q;

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_zero    = rsp_zero_q;
  assign bus.rsp_greater = rsp_greater_q;
  assign bus.rsp_carry   = rsp_carry_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.alu_sc_in   = alu_sc_in_q;

  // Effective B operand and low-pass carry-in: SUB feeds ~B with carry-in 1.
  logic [W_DATA-1:0] req_b_eff;
  logic              lo_cin;
`ifdef SEQ_SUB_EN
  assign req_b_eff = (bus.req_op == 3'd4) ? ~bus.req_b : bus.req_b;
  assign lo_cin    = (bus.req_op == 3'd4);
`else
  assign req_b_eff = bus.req_b;
  assign lo_cin    = 1'b0;
`endif

  function automatic logic legal(input logic [2:0] op);
`ifdef SEQ_SUB_EN
    return op <= 3'd4;
`else
    return op <= 3'd3;
`endif
  endfunction

  // ops whose carry chains across the passes and is reported
  function automatic logic carry_op(input logic [2:0] op);
    return (op == 3'd0) || (op == 3'd4);
  endfunction

  function automatic logic [3:0] map_op(input logic [2:0] op);
    case (op)
      3'd0:    return kADD;
      3'd1:    return kXOR;
      3'd2:    return kAND;
      3'd3:    return kCOMP;
      3'd4:    return kADD;
      default: return kAND;
    endcase
  endfunction

  // Carry out of the byte currently on the ALU inputs; the ALU's own SC_OUT is not trusted.
  function automatic logic carry8(input logic [W_ALU-1:0] a, input logic [W_ALU-1:0] b,
                                  input logic cin);
    logic [W_ALU:0] s;
    s = {1'b0, a} + {1'b0, b} + {{W_ALU{1'b0}}, cin};
    return s[W_ALU];
  endfunction

  logic              pass_carry;
  logic [W_DATA-1:0] res_full;
  assign pass_carry = carry8(alu_a_q, alu_b_q, alu_sc_in_q);
  assign res_full   = {bus.alu_out, res_lo};

  // Sequencer FSM: accept, low pass, high pass, hold response until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      req           <= '0;
      res_lo        <= '0;
      z_lo          <= 1'b0;
      g_lo          <= 1'b0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_greater_q <= 1'b0;
      rsp_carry_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= kAND;
      alu_sc_in_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            req         <= '{op: bus.req_op, a: bus.req_a, b: req_b_eff};
            req_ready_q <= 1'b0;
            state       <= LO;
            // illegal ops leave the ALU inputs at their idle values
            if (legal(bus.req_op)) begin
              alu_a_q     <= bus.req_a[W_ALU-1:0];
              alu_b_q     <= req_b_eff[W_ALU-1:0];
              alu_op_q    <= map_op(bus.req_op);
              alu_sc_in_q <= lo_cin;
            end
          end
        end
        LO: begin
          if (!legal(req.op)) begin
            state         <= DONE;
            rsp_valid_q   <= 1'b1;
            rsp_result_q  <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_greater_q <= 1'b0;
            rsp_carry_q   <= 1'b0;
            rsp_err_q     <= 1'b1;
          end else begin
            res_lo      <= bus.alu_out;
            z_lo        <= bus.alu_zero;
            g_lo        <= bus.alu_greater;
            alu_a_q     <= req.a[W_DATA-1:W_ALU];
            alu_b_q     <= req.b[W_DATA-1:W_ALU];
            alu_sc_in_q <= carry_op(req.op) & pass_carry;
            state       <= HI;
          end
        end
        HI: begin
          state       <= DONE;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          if (req.op == 3'd3) begin
            // high byte decides unless equal, then low byte decides
            rsp_result_q  <= '0;
            rsp_carry_q   <= 1'b0;
            rsp_zero_q    <= bus.alu_zero & z_lo;
            rsp_greater_q <= bus.alu_greater | (bus.alu_zero & g_lo);
          end else begin
            rsp_result_q  <= res_full;
            rsp_zero_q    <= (res_full == '0);
            rsp_greater_q <= 1'b0;
            rsp_carry_q   <= carry_op(req.op) & pass_carry;
          end
          alu_a_q     <= '0;
          alu_b_q     <= '0;
          alu_op_q    <= kAND;
          alu_sc_in_q <= 1'b0;
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Self-checking bench for alu_wide_sequencer: a behavioural 8-bit ALU model,
// directed cases, backpressure, illegal op, mid-operation reset and a random
// run, all checked against a 16-bit arithmetic reference model.
// Honours SEQ_SUB_EN the same way the design does.
module tb_alu_wide_sequencer;
  import alu_wide_sequencer_pkg::*;

  typedef struct packed {
    logic [15:0] result;
    logic        zero;
    logic        greater;
    logic        carry;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_wide_sequencer_if #(.W_DATA(16)) bus();
  alu_wide_sequencer #(.W_DATA(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Combinational 8-bit ALU; COMP returns junk on OUT to show it is ignored.
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum         = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'd0, bus.alu_sc_in};
    bus.alu_out     = 8'h00;
    bus.alu_greater = 1'b0;
    case (bus.alu_op)
      kADD:  bus.alu_out = alu_sum[7:0];
      kXOR:  bus.alu_out = bus.alu_a ^ bus.alu_b;
      kAND:  bus.alu_out = bus.alu_a & bus.alu_b;
      kCOMP: begin
        bus.alu_out     = bus.alu_a ^ bus.alu_b ^ 8'h5A;
        bus.alu_greater = bus.alu_a > bus.alu_b;
      end
      default: bus.alu_out = 8'h00;
    endcase
    bus.alu_zero = (bus.alu_op == kCOMP) ? (bus.alu_a == bus.alu_b) : (bus.alu_out == 8'h00);
  end

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic legal_op(input logic [2:0] op);
`ifdef SEQ_SUB_EN
    return op <= 3'd4;
`else
    return op <= 3'd3;
`endif
  endfunction

  // 16-bit reference: what the operation means, not how the passes compute it.
  function automatic rsp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    rsp_t r = '0;
    logic [16:0] s;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r.result = s[15:0]; r.carry = s[16]; end
      3'd1: r.result = a ^ b;
      3'd2: r.result = a & b;
      3'd3: begin r.zero = (a == b); r.greater = (a > b); end
`ifdef SEQ_SUB_EN
      3'd4: begin r.result = a - b; r.carry = (a >= b); end
`endif
      default: r.err = 1'b1;
    endcase
    if (op != 3'd3 && !r.err) r.zero = (r.result == 16'h0000);
    return r;
  endfunction

  function automatic logic [3:0] exp_alu_op(input logic [2:0] op);
    case (op)
      3'd1:    return kXOR;
      3'd2:    return kAND;
      3'd3:    return kCOMP;
      default: return kADD;
    endcase
  endfunction

  function automatic logic exp_hi_cin(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    if (op == 3'd0) return (a[7:0] + b[7:0]) > 255;
    if (op == 3'd4) return a[7:0] >= b[7:0];
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  rsp_t       got;
  logic [7:0] lo_a, lo_b, lo_out, hi_a;
  logic [3:0] lo_op;
  logic       lo_sc, hi_sc;
  int         lat;

  always_comb got = '{bus.rsp_result, bus.rsp_zero, bus.rsp_greater, bus.rsp_carry, bus.rsp_err};

  // Present a request, wait for the accept, then count edges to RSP_VALID while
  // snapshotting the ALU inputs of each pass.
  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int t = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
    while (!bus.req_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("accept_timeout", 32'(t), 32'd0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_a = 16'($urandom); bus.req_b = 16'($urandom);
    bus.req_op = 3'($urandom);
    lat = 0;
    while (!bus.rsp_valid && lat < 10) begin
      if (lat == 0) begin lo_a = bus.alu_a; lo_b = bus.alu_b; lo_op = bus.alu_op; lo_sc = bus.alu_sc_in; lo_out = bus.alu_out; end
      if (lat == 1) begin hi_a = bus.alu_a; hi_sc = bus.alu_sc_in; end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_rsp(input string tag, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    rsp_t e = model(op, a, b);
    chk({tag, ".latency"}, 32'(lat), e.err ? 32'd1 : 32'd2);
    chk({tag, ".result"},  32'(got.result),  32'(e.result));
    chk({tag, ".zero"},    32'(got.zero),    32'(e.zero));
    chk({tag, ".greater"}, 32'(got.greater), 32'(e.greater));
    chk({tag, ".carry"},   32'(got.carry),   32'(e.carry));
    chk({tag, ".err"},     32'(got.err),     32'(e.err));
    chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'd0);
    if (legal_op(op)) begin
      chk({tag, ".lo_a"},  32'(lo_a),  32'(a[7:0]));
      chk({tag, ".lo_op"}, 32'(lo_op), 32'(exp_alu_op(op)));
      chk({tag, ".lo_sc"}, 32'(lo_sc), 32'(op == 3'd4));
      chk({tag, ".hi_a"},  32'(hi_a),  32'(a[15:8]));
      chk({tag, ".hi_sc"}, 32'(hi_sc), 32'(exp_hi_cin(op, a, b)));
    end else begin
      chk({tag, ".idle_op"}, 32'(lo_op), 32'(kAND));
      chk({tag, ".idle_a"},  32'(lo_a),  32'd0);
    end
  endtask

  task automatic consume(input string tag);
    @(negedge clk); bus.rsp_ready = 1'b1;
    @(posedge clk); #1; bus.rsp_ready = 1'b0;
    chk({tag, ".rsp_valid_drop"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, ".req_ready_back"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    rsp_t e;
    bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_a = 16'h0; bus.req_b = 16'h0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.rsp", 32'(got), 32'd0);
    chk("reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset.req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset.alu_a", 32'(bus.alu_a), 32'd0);
    chk("reset.alu_b", 32'(bus.alu_b), 32'd0);
    chk("reset.alu_sc", 32'(bus.alu_sc_in), 32'd0);
    chk("reset.alu_op", 32'(bus.alu_op), 32'(kAND));
    @(negedge clk); rst_n = 1'b1;

    // ADD with low-byte carry into the high pass
    issue(3'd0, 16'h00FF, 16'h0001);
    check_rsp("add_ff_1", 3'd0, 16'h00FF, 16'h0001);
    chk("add_ff_1.lo_out", 32'(lo_out), 32'h00);
    chk("add_ff_1.hi_sc_const", 32'(hi_sc), 32'd1);
    chk("add_ff_1.result_const", 32'(got.result), 32'h0100);
    consume("add_ff_1");

    issue(3'd0, 16'hFFFF, 16'h0001);
    check_rsp("add_wrap", 3'd0, 16'hFFFF, 16'h0001);
    chk("add_wrap.zc_const", 32'({got.zero, got.carry}), 32'b11);
    consume("add_wrap");

    issue(3'd1, 16'hA5A5, 16'h5A5A);
    check_rsp("xor", 3'd1, 16'hA5A5, 16'h5A5A);
    consume("xor");

    issue(3'd2, 16'hF0F0, 16'h0F0F);
    check_rsp("and_zero", 3'd2, 16'hF0F0, 16'h0F0F);
    consume("and_zero");

    issue(3'd3, 16'h1200, 16'h11FF);
    check_rsp("comp_gt", 3'd3, 16'h1200, 16'h11FF);
    chk("comp_gt.greater_const", 32'(got.greater), 32'd1);
    consume("comp_gt");
    issue(3'd3, 16'h3434, 16'h3434);
    check_rsp("comp_eq", 3'd3, 16'h3434, 16'h3434);
    consume("comp_eq");
    issue(3'd3, 16'h0001, 16'h0100);
    check_rsp("comp_lt", 3'd3, 16'h0001, 16'h0100);
    consume("comp_lt");
    issue(3'd3, 16'h5581, 16'h5580);
    check_rsp("comp_lo_decides", 3'd3, 16'h5581, 16'h5580);
    consume("comp_lo_decides");

    // SUB, or illegal op 4 when the feature is absent
    issue(3'd4, 16'h0100, 16'h0001);
    check_rsp("op4_a", 3'd4, 16'h0100, 16'h0001);
    consume("op4_a");
    issue(3'd4, 16'h0000, 16'h0001);
    check_rsp("op4_b", 3'd4, 16'h0000, 16'h0001);
`ifdef SEQ_SUB_EN
    chk("sub_borrow.result_const", 32'(got.result), 32'hFFFF);
    chk("sub_borrow.carry_const", 32'(got.carry), 32'd0);
`else
    chk("op4_illegal.err_const", 32'(got.err), 32'd1);
`endif
    consume("op4_b");

    // illegal op
    issue(3'd5, 16'h1234, 16'h5678);
    check_rsp("illegal5", 3'd5, 16'h1234, 16'h5678);
    consume("illegal5");

    // backpressure: response held, second request waits
    issue(3'd0, 16'h1234, 16'h0F0F);
    check_rsp("bp_first", 3'd0, 16'h1234, 16'h0F0F);
    e = model(3'd0, 16'h1234, 16'h0F0F);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 3'd1; bus.req_a = 16'hBEEF; bus.req_b = 16'h1111;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp.rsp_stable", 32'(got), 32'(e));
      chk("bp.rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp.req_ready", 32'(bus.req_ready), 32'd0);
    end
    consume("bp_first");
    issue(3'd1, 16'hBEEF, 16'h1111);
    check_rsp("bp_second", 3'd1, 16'hBEEF, 16'h1111);
    consume("bp_second");

    // reset while in the high pass
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 3'd0; bus.req_a = 16'h7777; bus.req_b = 16'h8888;
    @(posedge clk); #1; bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid.in_hi", 32'(bus.alu_a), 32'h77);
    rst_n = 1'b0; #1;
    chk("rst_mid.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_mid.req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_mid.alu_op", 32'(bus.alu_op), 32'(kAND));
    chk("rst_mid.alu_a", 32'(bus.alu_a), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("rst_mid.no_rsp", 32'(bus.rsp_valid), 32'd0);
    end

    // random run
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [15:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = 16'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      if ($urandom_range(0, 3) == 0) b[15:8] = a[15:8];
      issue(op, a, b);
      check_rsp($sformatf("rand%0d", i), op, a, b);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      chk($sformatf("rand%0d.hold", i), 32'(got), 32'(model(op, a, b)));
      consume($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_wide_sequencer.md
Name: alu_wide_sequencer

Overview:
Multi-cycle initiator that executes 16-bit operations on the 8-bit combinational ALU. It runs two byte passes, low byte then high byte, and chains the carry between them. It sits between the control unit, which uses a valid/ready request/response interface, and the ALU operand/opcode inputs. ALU opcodes come from the definitions package enum (kADD, kXOR, kAND, kCOMP).

Parameters:
W_DATA, 16, request operand/result width; must equal 2x the ALU width of 8.

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
REQ_VALID  input  1  request valid
REQ_READY  output  1  request accepted when VALID&&READY at CLK edge
REQ_OP  input  3  0=ADD, 1=XOR, 2=AND, 3=COMP, 4=SUB (optional), others illegal
REQ_A  input  16  operand A
REQ_B  input  16  operand B
RSP_VALID  output  1  response valid
RSP_READY  input  1  response consumed when VALID&&READY at CLK edge
RSP_RESULT  output  16  result
RSP_ZERO  output  1  zero flag
RSP_GREATER  output  1  A>B unsigned; COMP only
RSP_CARRY  output  1  carry out of bit 15 (ADD/SUB)
RSP_ERR  output  1  illegal REQ_OP
ALU_A  output  8  ALU INPUTA
ALU_B  output  8  ALU INPUTB
ALU_OP  output  4  ALU opcode
ALU_SC_IN  output  1  ALU carry in
ALU_OUT  input  8  ALU result
ALU_ZERO  input  1  ALU zero flag
ALU_GREATER  input  1  ALU greater flag

Behaviour:
- States: IDLE, LO, HI, DONE. Reset (async, RST_N=0) forces IDLE.
- Reset values: all RSP_* = 0, REQ_READY = 1, ALU_A/ALU_B/ALU_SC_IN = 0, ALU_OP = kAND.
- IDLE: REQ_READY=1. On handshake, latch REQ_OP/A/B and go to LO.
- Illegal op: go directly to DONE with RESULT=0, flags=0, RSP_ERR=1. No ALU pass is issued.
- LO: drive ALU_A=A[7:0], ALU_B=B[7:0], ALU_SC_IN=0, ALU_OP per op.
  - At the edge, capture ALU_OUT into res_lo, ALU_ZERO into z_lo, and ALU_GREATER into g_lo.
  - Compute carry internally as bit 8 of {1'b0,ALU_A}+ALU_B+ALU_SC_IN. The ALU SC_OUT is not used.
  - Go to HI.
- HI: drive A[15:8], B[15:8]. ALU_SC_IN = lo carry for ADD/SUB, else 0.
  - At the edge, capture the high result, internal carry, and flags; go to DONE.
- DONE: RSP_VALID=1 and all RSP_* held stable until RSP_READY. On handshake, return to IDLE; RSP_VALID drops the next cycle.
- REQ_READY=0 in LO/HI/DONE. There is no overlap; minimum issue interval is 4 cycles.
- Latency: RSP_VALID rises 2 CLK edges after the request handshake edge.
- ALU_* outputs hold their reset values whenever the state is not LO or HI.
- Result and flags per op:
  - ADD/XOR/AND/SUB: RSP_RESULT={hi,lo}, RSP_ZERO=(RSP_RESULT==0), RSP_GREATER=0.
  - RSP_CARRY = HI-pass carry for ADD/SUB, else 0.
  - COMP: RSP_RESULT=0, RSP_CARRY=0. RSP_ZERO = z_hi & z_lo. RSP_GREATER = g_hi | (z_hi & g_lo). The ALU OUT is ignored for COMP.
- RSP_ERR=0 for legal ops.
- Reset mid-operation (any state): the transaction is dropped with no response, and the block returns to IDLE with reset values.
- A request presented while busy waits; REQ_A/B may change freely while REQ_READY=0.

Optional Feature:
- SEQ_SUB_EN defined: REQ_OP=4 is SUB, computing A-B as A + ~B + 1.
  - Both passes drive kADD with ALU_B = ~B byte. LO ALU_SC_IN=1; HI ALU_SC_IN = lo carry.
  - RSP_CARRY=1 means no borrow. RSP_ZERO = (result==0).
- SEQ_SUB_EN undefined: REQ_OP=4 is illegal (RSP_ERR=1, RESULT=0). No inversion logic is present.

Test Plan:
- ADD A=0x00FF, B=0x0001, RSP_READY=1 -> LO pass ALU_OUT=0x00 with carry; HI ALU_SC_IN=1; RESULT=0x0100, CARRY=0, ZERO=0; RSP_VALID 2 edges after accept.
- ADD A=0xFFFF, B=0x0001 -> RESULT=0x0000, ZERO=1, CARRY=1. XOR 0xA5A5^0x5A5A -> 0xFFFF, ZERO=0, CARRY=0.
- COMP 0x1200 vs 0x11FF -> GREATER=1, ZERO=0. COMP 0x3434 vs 0x3434 -> ZERO=1, GREATER=0. COMP 0x0001 vs 0x0100 -> both 0; RESULT=0.
- Backpressure: RSP_READY=0 for 5 cycles after RSP_VALID -> RSP_* stable, REQ_READY=0, second REQ_VALID not accepted; RSP_READY=1 -> next cycle IDLE, second request accepted.
- REQ_OP=5 -> RSP_VALID after 1 edge, RSP_ERR=1, RESULT=0, ALU_OP stays kAND. RST_N low during HI -> immediate IDLE, RSP_VALID=0, REQ_READY=1, no response after release.
- With SEQ_SUB_EN: SUB 0x0100-0x0001 -> 0x00FF, CARRY=1; SUB 0x0000-0x0001 -> 0xFFFF, CARRY=0. Without SEQ_SUB_EN: REQ_OP=4 -> RSP_ERR=1.
